bus_arbiter_2m: RTL and testbench

Two-master arbiter that shares the processor's single 32-bit data-memory port between the CPU load/store unit (master 0) and a peripheral/DMA master (master 1). It latches the winning master's request, drives the shared slave port for a fixed number of wait cycles, and returns read data with a one-cycle completion pulse. Its `sel_o` output drives the 2:1 select of the 32-bit data-path multiplexers in front of the memory port. Fairness is round-robin.

---
 rtl/bus_arbiter_2m_if.sv | 42 ++++
 rtl/bus_arbiter_2m.sv | 133 +++++++++++++
 tb/tb_bus_arbiter_2m.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_2m_if.sv
// Bus bundle between two requesting masters, the arbiter and the shared
// data-memory slave port. The arbiter uses the slave modport; whatever
// drives the master side uses the master modport.
interface bus_arbiter_2m_if;
   logic        m0_req_i;
   logic        m1_req_i;
   logic        m0_we_i;
   logic        m1_we_i;
   logic [31:0] m0_addr_i;
   logic [31:0] m1_addr_i;
   logic [31:0] m0_wdata_i;
   logic [31:0] m1_wdata_i;
   logic        m0_gnt_o;
   logic        m1_gnt_o;
   logic        m0_done_o;
   logic        m1_done_o;
   logic [31:0] rdata_o;
   logic        s_en_o;
   logic        s_we_o;
   logic [31:0] s_addr_o;
   logic [31:0] s_wdata_o;
   logic [31:0] s_rdata_i;
   logic        sel_o;

   // Arbiter side: takes requests and slave read data, drives everything else.
   modport slave (
      input  m0_req_i, m1_req_i, m0_we_i, m1_we_i,
      input  m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
      input  s_rdata_i,
      output m0_gnt_o, m1_gnt_o, m0_done_o, m1_done_o, rdata_o,
      output s_en_o, s_we_o, s_addr_o, s_wdata_o, sel_o
   );

   // Master/memory side: drives requests and slave read data.
   modport master (
      output m0_req_i, m1_req_i, m0_we_i, m1_we_i,
      output m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
      output s_rdata_i,
      input  m0_gnt_o, m1_gnt_o, m0_done_o, m1_done_o, rdata_o,
      input  s_en_o, s_we_o, s_addr_o, s_wdata_o, sel_o
   );
endinterface

// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin arbiter for the single 32-bit data-memory port.
// The winning request is latched in IDLE, the slave port is driven from the
// latched copy for LAT cycles, then a one-cycle done pulse returns read data.
// Every output is a register or a decode of registers, so no request input
// reaches an output combinationally.
module bus_arbiter_2m #(
   parameter int unsigned LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   bus_arbiter_2m_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Wait counter preload: counts LAT-1 down to 0, one ACCESS cycle each.
   localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

   state_t      state_reg, state_next;
   logic        owner_reg, owner_next;
   logic        last_reg, last_next;
   logic        first_reg, first_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        we_reg, we_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] wdata_reg, wdata_next;
   logic [31:0] rdata_reg, rdata_next;

   logic        any_req;
   logic        pick;

   // Winner selection: a lone request wins outright, a tie goes to the
   // master that was not granted last.
   always_comb begin
      any_req = bus.m0_req_i | bus.m1_req_i;
      if (bus.m0_req_i && bus.m1_req_i) begin
         pick = ~last_reg;
      end else begin
         pick = bus.m1_req_i;
      end
   end

   // Next-state and register-update logic for the transaction FSM.
   always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      last_next  = last_reg;
      first_next = first_reg;
      cnt_next   = cnt_reg;
      we_next    = we_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      rdata_next = rdata_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               owner_next = pick;
               we_next    = pick ? bus.m1_we_i    : bus.m0_we_i;
               addr_next  = pick ? bus.m1_addr_i  : bus.m0_addr_i;
               wdata_next = pick ? bus.m1_wdata_i : bus.m0_wdata_i;
               cnt_next   = CNT_LOAD;
               first_next = 1'b1;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            first_next = 1'b0;
            if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               // Slave data is sampled at the edge closing the last access cycle.
               if (!we_reg) begin
                  rdata_next = bus.s_rdata_i;
               end
               last_next  = owner_reg;
               state_next = DONE;
            end
         end
         DONE: begin
            // No grant here: the pending request is seen in the next IDLE cycle.
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any transaction silently.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         owner_reg <= 1'b0;
         last_reg  <= 1'b1;
         first_reg <= 1'b0;
         cnt_reg   <= 4'd0;
         we_reg    <= 1'b0;
         addr_reg  <= 32'd0;
         wdata_reg <= 32'd0;
         rdata_reg <= 32'd0;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         last_reg  <= last_next;
         first_reg <= first_next;
         cnt_reg   <= cnt_next;
         we_reg    <= we_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         rdata_reg <= rdata_next;
      end
   end

   // Output decode from registers only; slave fields always come from the
   // latched copy so late master changes cannot disturb an access.
   always_comb begin
      bus.s_en_o    = (state_reg == ACCESS);
      bus.s_we_o    = we_reg;
      bus.s_addr_o  = addr_reg;
      bus.s_wdata_o = wdata_reg;
      bus.rdata_o   = rdata_reg;
      bus.sel_o     = owner_reg;
      bus.m0_gnt_o  = (state_reg == ACCESS) && first_reg && !owner_reg;
      bus.m1_gnt_o  = (state_reg == ACCESS) && first_reg &&  owner_reg;
      bus.m0_done_o = (state_reg == DONE) && !owner_reg;
      bus.m1_done_o = (state_reg == DONE) &&  owner_reg;
   end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed bench for bus_arbiter_2m: dut_a runs with LAT=2, dut_b with LAT=4
// for the mid-access reset case. Outputs are sampled 1 time unit after the
// rising edge, and inputs are driven at the same point.
module tb_bus_arbiter_2m;
   localparam int LAT_A = 2;
   localparam int LAT_B = 4;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   errors;
   int   checks;

   bus_arbiter_2m_if ia ();
   bus_arbiter_2m_if ib ();

   bus_arbiter_2m #(.LAT(LAT_A)) dut_a (
      .clk_i (clk),
      .rst_i (rst_a),
      .bus   (ia)
   );

   bus_arbiter_2m #(.LAT(LAT_B)) dut_b (
      .clk_i (clk),
      .rst_i (rst_b),
      .bus   (ib)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_a  = 1'b0;
      rst_b  = 1'b0;
      ia.m0_req_i = 0; ia.m1_req_i = 0; ia.m0_we_i = 0; ia.m1_we_i = 0;
      ia.m0_addr_i = 0; ia.m1_addr_i = 0; ia.m0_wdata_i = 0; ia.m1_wdata_i = 0;
      ia.s_rdata_i = 0;
      ib.m0_req_i = 0; ib.m1_req_i = 0; ib.m0_we_i = 0; ib.m1_we_i = 0;
      ib.m0_addr_i = 0; ib.m1_addr_i = 0; ib.m0_wdata_i = 0; ib.m1_wdata_i = 0;
      ib.s_rdata_i = 0;

      // Asynchronous reset between edges: outputs must clear at once.
      #3;
      rst_a = 1'b1;
      rst_b = 1'b1;
      #1;
      check("rst sel",    32'(ia.sel_o), 32'd0);
      check("rst rdata",  ia.rdata_o, 32'd0);
      check("rst s_en",   32'(ia.s_en_o), 32'd0);
      check("rst s_we",   32'(ia.s_we_o), 32'd0);
      check("rst s_addr", ia.s_addr_o, 32'd0);
      check("rst s_wdat", ia.s_wdata_o, 32'd0);
      check("rst gnt",    32'({ia.m0_gnt_o, ia.m1_gnt_o}), 32'd0);
      check("rst done",   32'({ia.m0_done_o, ia.m1_done_o}), 32'd0);
      #17;
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Idle with no requests.
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle s_en", 32'(ia.s_en_o), 32'd0);
      end

      // m0 read, LAT=2.
      ia.m0_req_i  = 1'b1;
      ia.m0_we_i   = 1'b0;
      ia.m0_addr_i = 32'h0000_0010;
      ia.s_rdata_i = 32'hDEAD_BEEF;
      step();
      check("rd gnt0",   32'(ia.m0_gnt_o), 32'd1);
      check("rd gnt1",   32'(ia.m1_gnt_o), 32'd0);
      check("rd s_en1",  32'(ia.s_en_o), 32'd1);
      check("rd s_addr", ia.s_addr_o, 32'h0000_0010);
      check("rd s_we",   32'(ia.s_we_o), 32'd0);
      step();
      check("rd gnt0 off", 32'(ia.m0_gnt_o), 32'd0);
      check("rd s_en2",    32'(ia.s_en_o), 32'd1);
      check("rd done early", 32'(ia.m0_done_o), 32'd0);
      step();
      check("rd done0", 32'(ia.m0_done_o), 32'd1);
      check("rd rdata", ia.rdata_o, 32'hDEAD_BEEF);
      check("rd s_en3", 32'(ia.s_en_o), 32'd0);
      check("rd sel",   32'(ia.sel_o), 32'd0);
      ia.m0_req_i = 1'b0;
      step();

      // Round-robin under continuous ties, starting from a fresh reset.
      #2 rst_a = 1'b1;
      #2 rst_a = 1'b0;
      #1;
      ia.m0_req_i = 1'b1;
      ia.m1_req_i = 1'b1;
      ia.m1_we_i  = 1'b0;
      ia.m1_addr_i = 32'h0000_0080;
      step();
      check("rr g0 gnt0", 32'(ia.m0_gnt_o), 32'd1);
      check("rr g0 gnt1", 32'(ia.m1_gnt_o), 32'd0);
      check("rr g0 sel",  32'(ia.sel_o), 32'd0);
      for (int n = 1; n < 4; n++) begin
         for (int t = 1; t <= LAT_A + 2; t++) begin
            step();
            if (t == LAT_A) begin
               check("rr done0", 32'(ia.m0_done_o), 32'((n - 1) % 2 == 0));
               check("rr done1", 32'(ia.m1_done_o), 32'((n - 1) % 2 == 1));
            end
            if (t == LAT_A + 1) begin
               check("rr idle s_en", 32'(ia.s_en_o), 32'd0);
               check("rr idle gnt",  32'({ia.m0_gnt_o, ia.m1_gnt_o}), 32'd0);
            end
            if (t == LAT_A + 2) begin
               check("rr gnt0", 32'(ia.m0_gnt_o), 32'(n % 2 == 0));
               check("rr gnt1", 32'(ia.m1_gnt_o), 32'(n % 2 == 1));
               check("rr sel",  32'(ia.sel_o), 32'(n % 2));
            end
         end
      end
      ia.m0_req_i = 1'b0;
      ia.m1_req_i = 1'b0;
      for (int t = 1; t <= LAT_A; t++) step();
      check("rr last done1", 32'(ia.m1_done_o), 32'd1);
      check("rr last rdata", ia.rdata_o, 32'hDEAD_BEEF);
      step();

      // m1 write; master scribbles its fields after the grant.
      ia.s_rdata_i  = 32'h0BAD_F00D;
      ia.m1_req_i   = 1'b1;
      ia.m1_we_i    = 1'b1;
      ia.m1_addr_i  = 32'h0000_0100;
      ia.m1_wdata_i = 32'h1234_5678;
      step();
      check("wr gnt1",    32'(ia.m1_gnt_o), 32'd1);
      check("wr sel",     32'(ia.sel_o), 32'd1);
      check("wr s_we a",  32'(ia.s_we_o), 32'd1);
      check("wr s_addr a", ia.s_addr_o, 32'h0000_0100);
      check("wr s_wdat a", ia.s_wdata_o, 32'h1234_5678);
      ia.m1_addr_i  = 32'hFFFF_FFFF;
      ia.m1_wdata_i = 32'hFFFF_FFFF;
      step();
      check("wr s_en b",   32'(ia.s_en_o), 32'd1);
      check("wr s_we b",   32'(ia.s_we_o), 32'd1);
      check("wr s_addr b", ia.s_addr_o, 32'h0000_0100);
      check("wr s_wdat b", ia.s_wdata_o, 32'h1234_5678);
      step();
      check("wr done1", 32'(ia.m1_done_o), 32'd1);
      check("wr rdata", ia.rdata_o, 32'hDEAD_BEEF);
      ia.m1_req_i = 1'b0;
      step();

      // Request dropped in the first access cycle.
      ia.s_rdata_i = 32'h55AA_55AA;
      ia.m0_req_i  = 1'b1;
      ia.m0_we_i   = 1'b0;
      ia.m0_addr_i = 32'h0000_0020;
      step();
      check("drop gnt0", 32'(ia.m0_gnt_o), 32'd1);
      check("drop sel",  32'(ia.sel_o), 32'd0);
      ia.m0_req_i = 1'b0;
      step();
      check("drop s_en", 32'(ia.s_en_o), 32'd1);
      step();
      check("drop done0", 32'(ia.m0_done_o), 32'd1);
      check("drop rdata", ia.rdata_o, 32'h55AA_55AA);
      for (int i = 0; i < 4; i++) begin
         step();
         check("drop no regrant", 32'({ia.m0_gnt_o, ia.s_en_o}), 32'd0);
      end
      check("drop sel held", 32'(ia.sel_o), 32'd0);

      // Reset in the second access cycle of a LAT=4 transaction.
      ib.m1_req_i  = 1'b1;
      ib.m1_we_i   = 1'b0;
      ib.m1_addr_i = 32'h0000_0040;
      ib.s_rdata_i = 32'h7777_7777;
      step();
      check("mr gnt1", 32'(ib.m1_gnt_o), 32'd1);
      step();
      check("mr s_en", 32'(ib.s_en_o), 32'd1);
      check("mr s_addr", ib.s_addr_o, 32'h0000_0040);
      #2 rst_b = 1'b1;
      #1;
      check("mr rst s_en",   32'(ib.s_en_o), 32'd0);
      check("mr rst sel",    32'(ib.sel_o), 32'd0);
      check("mr rst s_addr", ib.s_addr_o, 32'd0);
      check("mr rst done",   32'({ib.m0_done_o, ib.m1_done_o}), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("mr hold done", 32'({ib.m0_done_o, ib.m1_done_o}), 32'd0);
      end
      rst_b = 1'b0;
      ib.m0_req_i = 1'b1;
      ib.m0_addr_i = 32'h0000_0044;
      step();
      check("mr tie gnt0", 32'(ib.m0_gnt_o), 32'd1);
      check("mr tie gnt1", 32'(ib.m1_gnt_o), 32'd0);
      check("mr tie sel",  32'(ib.sel_o), 32'd0);
      for (int t = 1; t <= LAT_B; t++) step();
      check("mr done0", 32'(ib.m0_done_o), 32'd1);
      check("mr done1", 32'(ib.m1_done_o), 32'd0);
      check("mr rdata", ib.rdata_o, 32'h7777_7777);
      ib.m0_req_i = 1'b0;
      ib.m1_req_i = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
